// File: rtl/imm_gen_pipe.sv
// Immediate expander feeding a 2-entry FIFO with valid/ready on both sides.
// Illegal type codes pass through as a zero immediate with a flag and a saturating count.
module imm_gen_pipe (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [2:0]  i_src_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_imm,
  output logic [2:0]  o_src_imm,
  output logic        o_illegal,
  output logic [7:0]  o_illegal_cnt
);

  localparam logic [2:0] CODE_R = 3'b000;
  localparam logic [2:0] CODE_I = 3'b001;
  localparam logic [2:0] CODE_S = 3'b010;
  localparam logic [2:0] CODE_B = 3'b011;
  localparam logic [2:0] CODE_J = 3'b100;
  localparam logic [2:0] CODE_U = 3'b101;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  code;
    logic        ill;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      last_q, last_d;
  entry_t      head;
  entry_t      new_entry;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  ill_cnt_q, ill_cnt_d;
  logic        push, pop;

  always_comb begin
    new_entry      = '0;
    new_entry.code = i_src_imm;
    unique case (i_src_imm)
      CODE_R: new_entry.imm = 32'h0;
      CODE_I: new_entry.imm = {{21{i_instr[31]}}, i_instr[30:20]};
      CODE_S: new_entry.imm = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
      CODE_B: new_entry.imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                               i_instr[11:8], 1'b0};
      CODE_J: new_entry.imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                               i_instr[30:21], 1'b0};
      CODE_U: new_entry.imm = {i_instr[31:12], 12'h000};
      default: begin
        new_entry.imm = 32'h0;
        new_entry.ill = 1'b1;
      end
    endcase
  end

  assign o_ready = i_rstn && (count_q < 2'd2);
  assign o_valid = (count_q != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  assign head    = mem_q[rd_ptr_q];

  // When the FIFO drains, the outputs keep showing the last head entry.
  assign o_imm         = o_valid ? head.imm  : last_q.imm;
  assign o_src_imm     = o_valid ? head.code : last_q.code;
  assign o_illegal     = o_valid ? head.ill  : last_q.ill;
  assign o_illegal_cnt = ill_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    last_d    = o_valid ? head : last_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
      if (new_entry.ill && (ill_cnt_q != 8'hFF)) begin
        ill_cnt_d = ill_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ill_cnt_q <= 8'd0;
    end else begin
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed scenarios plus random traffic against a queue-based model.
module tb_imm_gen_pipe;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [2:0]  i_src_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_imm;
  logic [2:0]  o_src_imm;
  logic        o_illegal;
  logic [7:0]  o_illegal_cnt;

  int n_checks = 0;
  int n_errors = 0;

  imm_gen_pipe dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_src_imm(i_src_imm), .o_valid(o_valid), .i_ready(i_ready),
    .o_imm(o_imm), .o_src_imm(o_src_imm), .o_illegal(o_illegal),
    .o_illegal_cnt(o_illegal_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  code;
    logic        ill;
  } item_t;

  item_t m_q[$];
  item_t m_last;
  int    m_ill_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic item_t expand(input logic [31:0] ins, input logic [2:0] code);
    item_t it;
    int    v;
    v = 0;
    it.ill = 1'b0;
    case (code)
      3'd1: v = $signed(ins[31:20]);
      3'd2: v = $signed({ins[31:25], ins[11:7]});
      3'd3: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd5: v = int'(ins & 32'hFFFFF000);
      3'd6, 3'd7: it.ill = 1'b1;
      default: v = 0;
    endcase
    it.imm  = v;
    it.code = code;
    return it;
  endfunction

  task automatic check_outputs(input string ctx);
    item_t exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : m_last;
    chk({ctx, "_ready"},   {31'd0, o_ready}, {31'd0, (i_rstn === 1'b1) && (m_q.size() < 2)});
    chk({ctx, "_valid"},   {31'd0, o_valid}, {31'd0, m_q.size() > 0});
    chk({ctx, "_imm"},     o_imm, exp_head.imm);
    chk({ctx, "_code"},    {29'd0, o_src_imm}, {29'd0, exp_head.code});
    chk({ctx, "_illegal"}, {31'd0, o_illegal}, {31'd0, exp_head.ill});
    chk({ctx, "_icnt"},    {24'd0, o_illegal_cnt}, m_ill_cnt[31:0]);
  endtask

  // One clock: apply inputs, advance model on the edge, compare just after it.
  task automatic cycle(input logic rstn, input logic v, input logic [31:0] ins,
                       input logic [2:0] code, input logic rdy, input string ctx);
    logic acc, pp;
    i_rstn    = rstn;
    i_valid   = v;
    i_instr   = ins;
    i_src_imm = code;
    i_ready   = rdy;
    acc = rstn && v && (m_q.size() < 2);
    pp  = rstn && rdy && (m_q.size() > 0);
    @(posedge i_clk);
    #1;
    if (!rstn) begin
      m_q.delete();
      m_last    = '{32'h0, 3'd0, 1'b0};
      m_ill_cnt = 0;
    end else begin
      if (pp) m_q.pop_front();
      if (acc) begin
        item_t it;
        it = expand(ins, code);
        m_q.push_back(it);
        if (it.ill && m_ill_cnt < 255) m_ill_cnt++;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
    check_outputs(ctx);
  endtask

  localparam logic [31:0] INS_I = 32'hFFF00093;
  localparam logic [31:0] INS_B = 32'hFE000EE3;
  localparam logic [31:0] INS_U = 32'h123450B7;
  localparam logic [31:0] INS_J = 32'h0080006F;
  localparam logic [31:0] INS_S = 32'hFE112E23;

  initial begin
    m_last    = '{32'h0, 3'd0, 1'b0};
    m_ill_cnt = 0;
    i_rstn = 1'b0; i_valid = 1'b0; i_instr = '0; i_src_imm = '0; i_ready = 1'b0;

    // Reset with garbage inputs that must be ignored.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'hDEADBEEF, 3'd6, 1'b1, "rst");
    chk("rst_ready_low", {31'd0, o_ready}, 32'd0);

    // Directed single expansions, streaming with i_ready high.
    cycle(1'b1, 1'b1, INS_I, 3'd1, 1'b1, "dirI");
    chk("I_imm", o_imm, 32'hFFFFFFFF);
    chk("I_valid", {31'd0, o_valid}, 32'd1);
    cycle(1'b1, 1'b1, INS_B, 3'd3, 1'b1, "dirB");
    chk("B_imm", o_imm, 32'hFFFFFFFC);
    cycle(1'b1, 1'b1, INS_U, 3'd5, 1'b1, "dirU");
    chk("U_imm", o_imm, 32'h12345000);
    cycle(1'b1, 1'b1, INS_J, 3'd4, 1'b1, "dirJ");
    chk("J_imm", o_imm, 32'h00000008);
    cycle(1'b1, 1'b1, INS_S, 3'd2, 1'b1, "dirS");
    chk("S_imm", o_imm, 32'hFFFFFFFC);
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, "drain");
    chk("drain_valid", {31'd0, o_valid}, 32'd0);
    chk("drain_hold", o_imm, 32'hFFFFFFFC);

    // Backpressure: two accepted, third blocked until a slot frees.
    cycle(1'b1, 1'b1, INS_I, 3'd1, 1'b0, "bp1");
    cycle(1'b1, 1'b1, INS_U, 3'd5, 1'b0, "bp2");
    chk("bp_full_ready", {31'd0, o_ready}, 32'd0);
    cycle(1'b1, 1'b1, INS_J, 3'd4, 1'b0, "bp3");
    chk("bp_stable", o_imm, 32'hFFFFFFFF);
    cycle(1'b1, 1'b1, INS_J, 3'd4, 1'b1, "bp4");
    chk("bp_second", o_imm, 32'h12345000);
    cycle(1'b1, 1'b1, INS_J, 3'd4, 1'b1, "bp5");
    chk("bp_third", o_imm, 32'h00000008);
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, "bp6");
    chk("bp_empty", {31'd0, o_valid}, 32'd0);

    // Illegal codes and counter saturation.
    cycle(1'b1, 1'b1, $urandom, 3'd6, 1'b1, "ill1");
    chk("ill_flag", {31'd0, o_illegal}, 32'd1);
    chk("ill_imm", o_imm, 32'h0);
    chk("ill_cnt1", {24'd0, o_illegal_cnt}, 32'd1);
    for (int k = 0; k < 299; k++) cycle(1'b1, 1'b1, $urandom, 3'd6 + 3'($urandom_range(0, 1)), 1'b1, "illsat");
    chk("ill_sat", {24'd0, o_illegal_cnt}, 32'hFF);
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, "illdrain");

    // Reset while full.
    cycle(1'b1, 1'b1, INS_I, 3'd1, 1'b0, "rf1");
    cycle(1'b1, 1'b1, INS_U, 3'd5, 1'b0, "rf2");
    cycle(1'b0, 1'b1, INS_J, 3'd4, 1'b1, "rf3");
    chk("rf_valid", {31'd0, o_valid}, 32'd0);
    chk("rf_icnt", {24'd0, o_illegal_cnt}, 32'd0);
    chk("rf_ready", {31'd0, o_ready}, 32'd0);
    cycle(1'b1, 1'b1, INS_J, 3'd4, 1'b1, "rf4");
    chk("rf_fresh", o_imm, 32'h00000008);
    chk("rf_fresh_valid", {31'd0, o_valid}, 32'd1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 99) != 0), 1'($urandom), $urandom, c, 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have the following ports:
- i_clk  input  1  rising-edge clock
- i_rstn  input  1  synchronous active-low reset
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  block can accept
- i_instr  input  32  fetched instruction word
- i_src_imm  input  3  immediate-type code
- o_valid  output  1  result valid
- i_ready  input  1  downstream can accept
- o_imm  output  32  expanded immediate
- o_src_imm  output  3  type code carried with o_imm
- o_illegal  output  1  type code of the presented entry was 110/111
- o_illegal_cnt  output  8  saturating count of illegal codes accepted

Function
REQ-003 The block SHALL decode i_src_imm as R=000, I=001, S=010, B=011, J=100, U=101; 110 and 111 are illegal.
REQ-004 The block SHALL expand the immediate as follows (ins = i_instr):
- R: 32'h0
- I: sign(ins[31]) x21, ins[30:20]
- S: sign x21, ins[30:25], ins[11:7]
- B: sign x20, ins[7], ins[30:25], ins[11:8], 0
- U: ins[31:12], 12'h000
- J: sign x12, ins[19:12], ins[20], ins[30:21], 0
- illegal: 32'h0 with the illegal flag set
REQ-005 The block SHALL accept an entry when i_valid && o_ready at a rising edge; the expansion is computed on accept and stored as {imm, code, illegal}.
REQ-006 Storage SHALL be a 2-entry FIFO (write pointer, read pointer, 2-bit count 0..2).
REQ-007 o_ready SHALL be 1 iff i_rstn is high and count < 2; it is derived combinationally from registered count.
REQ-008 o_valid SHALL be 1 iff count > 0; o_imm, o_src_imm and o_illegal SHALL show the head entry.
REQ-009 An entry SHALL pop when o_valid && i_ready at a rising edge.
REQ-010 There SHALL be no bypass: latency from accept to o_valid is exactly 1 cycle when the FIFO is empty.
REQ-011 Push and pop in the same cycle SHALL leave count unchanged; order is strictly FIFO.
REQ-012 When count == 2, pushes SHALL be blocked (o_ready = 0); a pop in that cycle frees a slot for the next cycle only.
REQ-013 When count == 0, pops SHALL be impossible (o_valid = 0); head outputs hold their last values.
REQ-014 Pointers SHALL wrap modulo 2.
REQ-015 o_illegal_cnt SHALL increment by 1 on each accept with an illegal code and saturate at 8'hFF.
REQ-016 Output fields SHALL be held stable while o_valid && !i_ready.

Reset
REQ-017 While i_rstn is 0 at a rising edge, the block SHALL clear count, both pointers, o_illegal_cnt and all storage to 0.
REQ-018 The reset values of all outputs SHALL be: o_valid = 0, o_imm = 0, o_src_imm = 0, o_illegal = 0, o_ready = 0 while i_rstn is low.
REQ-019 Reset mid-operation SHALL discard all buffered entries; inputs in the reset cycle are ignored.
REQ-020 The first accept SHALL be possible on the first edge with i_rstn = 1.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- I: instr 32'hFFF00093, code 001, i_ready = 1 -> next cycle o_valid = 1, o_imm = 32'hFFFFFFFF.
- B: 32'hFE000EE3 code 011 -> o_imm 32'hFFFFFFFC.
- U: 32'h123450B7 code 101 -> o_imm 32'h12345000.
- J: 32'h0080006F code 100 -> o_imm 32'h00000008.
- S: 32'hFE112E23 code 010 -> o_imm 32'hFFFFFFFC.
- Backpressure: i_ready = 0, present 3 valid items (I, U, J above) -> first two accepted, o_ready = 0 on the third. Then raise i_ready -> outputs FFFFFFFF, 12345000, then J accepted and output 00000008; no loss or duplication.
- Illegal: code 110 with any instr -> o_imm 0, o_illegal 1, o_illegal_cnt +1. 300 illegal accepts -> o_illegal_cnt = 8'hFF.
- Reset with count = 2 -> next cycle o_valid 0, o_illegal_cnt 0, o_ready 0 until i_rstn high. A fresh push then appears after 1 cycle.
